mem_bist_march_ctrl: RTL and testbench

//  Parametrised successor to the per-implementation BIST controllers: drives NUM_MEM macros in lockstep

---
 rtl/mem_bist_march_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_mem_bist_march_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bist_march_ctrl.sv
// mem_bist_march_ctrl
//   March C- BIST controller driving NUM_MEM memory macros in lockstep:
//   w0 up; r0w1 up; r1w0 down; r0 down. Read data is compared RD_LAT cycles
//   after each read, and the controller reports sticky per-memory fail flags
//   plus the address and march element of the first mismatch.
//
// Ports
//   bist_clk, bist_reset      clock, synchronous active-high reset
//   bist_on                   level start / abort request
//   bist_en[NUM_MEM]          per-memory access enable (all identical)
//   bist_we                   1=write, 0=read (shared)
//   bist_addr                 packed per-memory address, mem i at [i*ADDR_W +: ADDR_W]
//   bist_wr_data              packed write data, mem i at [i*DATA_W +: DATA_W]
//   bist_rd_data              packed read data, valid RD_LAT cycles after the read
//   bist_busy, bist_done      sequence status
//   bist_fail[NUM_MEM]        sticky per-memory mismatch flags
//   bist_fail_addr/phase      address and march element (1..3) of first mismatch
module mem_bist_march_ctrl #(
  parameter int NUM_MEM = 3,
  parameter int ADDR_W  = 4,
  parameter int DEPTH   = 16,
  parameter int DATA_W  = 73,
  parameter int RD_LAT  = 1
) (
  input  logic                      bist_clk,
  input  logic                      bist_reset,
  input  logic                      bist_on,
  output logic [NUM_MEM-1:0]        bist_en,
  output logic                      bist_we,
  output logic [NUM_MEM*ADDR_W-1:0] bist_addr,
  output logic [NUM_MEM*DATA_W-1:0] bist_wr_data,
  input  logic [NUM_MEM*DATA_W-1:0] bist_rd_data,
  output logic                      bist_busy,
  output logic                      bist_done,
  output logic [NUM_MEM-1:0]        bist_fail,
  output logic [ADDR_W-1:0]         bist_fail_addr,
  output logic [1:0]                bist_fail_phase
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(RD_LAT - 1);

  typedef enum logic [3:0] {
    IDLE, M0_W, M1_R, M1_W, M2_R, M2_W, M3_R, DRAIN, DONE
  } state_t;

  state_t            state;
  state_t            nxt_state;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] nxt_addr;
  logic [CNT_W-1:0]  drain_cnt;
  logic [CNT_W-1:0]  nxt_cnt;
  logic              abort;
  logic              nxt_op;
  logic [1:0]        op_phase;

  // Compare pipeline: entry k holds a read issued k+1 cycles ago.
  logic              cmp_vld_p   [RD_LAT];
  logic [ADDR_W-1:0] cmp_addr_p  [RD_LAT];
  logic [1:0]        cmp_phase_p [RD_LAT];
  logic [NUM_MEM-1:0] mism;

  // Only the M2 read element expects all-ones.
  function automatic logic expect_ones(input logic [1:0] phase);
    return phase == 2'd2;
  endfunction

  function automatic logic [1:0] phase_of(input state_t st);
    case (st)
      M1_R:    return 2'd1;
      M2_R:    return 2'd2;
      M3_R:    return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Next-state / address sequencing of the march elements.
  always_comb begin
    nxt_state = state;
    nxt_addr  = addr_q;
    nxt_cnt   = drain_cnt;
    abort     = 1'b0;
    case (state)
      IDLE: if (bist_on) begin
        nxt_state = M0_W;
        nxt_addr  = '0;
      end
      M0_W: if (addr_q == LAST_ADDR) begin
        nxt_state = M1_R;
        nxt_addr  = '0;
      end else begin
        nxt_addr = addr_q + 1'b1;
      end
      M1_R: nxt_state = M1_W;
      M1_W: if (addr_q == LAST_ADDR) begin
        nxt_state = M2_R;
      end else begin
        nxt_state = M1_R;
        nxt_addr  = addr_q + 1'b1;
      end
      M2_R: nxt_state = M2_W;
      M2_W: if (addr_q == '0) begin
        nxt_state = M3_R;
        nxt_addr  = LAST_ADDR;
      end else begin
        nxt_state = M2_R;
        nxt_addr  = addr_q - 1'b1;
      end
      M3_R: if (addr_q == '0) begin
        nxt_state = DRAIN;
        nxt_cnt   = '0;
      end else begin
        nxt_addr = addr_q - 1'b1;
      end
      DRAIN: if (drain_cnt == CNT_LAST) begin
        nxt_state = DONE;
      end else begin
        nxt_cnt = drain_cnt + 1'b1;
      end
      DONE: if (!bist_on) nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
    // Dropping bist_on anywhere in the run abandons it immediately.
    if (!bist_on && state != IDLE && state != DONE) begin
      abort     = 1'b1;
      nxt_state = IDLE;
    end
  end

  assign nxt_op = (nxt_state == M0_W) || (nxt_state == M1_R) || (nxt_state == M1_W) ||
                  (nxt_state == M2_R) || (nxt_state == M2_W) || (nxt_state == M3_R);

  always_comb begin
    mism = '0;
    for (int i = 0; i < NUM_MEM; i++) begin
      mism[i] = cmp_vld_p[RD_LAT-1] &&
                (bist_rd_data[i*DATA_W +: DATA_W] != {DATA_W{expect_ones(cmp_phase_p[RD_LAT-1])}});
    end
  end

  // Stage p0: FSM, registered memory-port outputs, compare valid chain and result flags.
  always_ff @(posedge bist_clk) begin
    if (bist_reset) begin
      state           <= IDLE;
      addr_q          <= '0;
      drain_cnt       <= '0;
      op_phase        <= 2'd0;
      bist_en         <= '0;
      bist_we         <= 1'b0;
      bist_addr       <= '0;
      bist_wr_data    <= '0;
      bist_busy       <= 1'b0;
      bist_done       <= 1'b0;
      bist_fail       <= '0;
      bist_fail_addr  <= '0;
      bist_fail_phase <= 2'd0;
      for (int k = 0; k < RD_LAT; k++) cmp_vld_p[k] <= 1'b0;
    end else begin
      state        <= nxt_state;
      addr_q       <= nxt_addr;
      drain_cnt    <= nxt_cnt;
      op_phase     <= phase_of(nxt_state);
      bist_en      <= {NUM_MEM{nxt_op}};
      bist_we      <= (nxt_state == M0_W) || (nxt_state == M1_W) || (nxt_state == M2_W);
      bist_addr    <= nxt_op ? {NUM_MEM{nxt_addr}} : '0;
      bist_wr_data <= {(NUM_MEM*DATA_W){nxt_state == M1_W}};
      bist_busy    <= nxt_op || (nxt_state == DRAIN);
      bist_done    <= (nxt_state == DONE);

      cmp_vld_p[0] <= bist_en[0] && !bist_we && !abort;
      for (int k = 1; k < RD_LAT; k++) cmp_vld_p[k] <= cmp_vld_p[k-1] && !abort;

      if (!abort && (mism != '0)) begin
        bist_fail <= bist_fail | mism;
        if (bist_fail == '0) begin
          bist_fail_addr  <= cmp_addr_p[RD_LAT-1];
          bist_fail_phase <= cmp_phase_p[RD_LAT-1];
        end
      end

      if (state == IDLE && bist_on) begin
        bist_fail       <= '0;
        bist_fail_addr  <= '0;
        bist_fail_phase <= 2'd0;
      end
    end
  end

  // Stage p1..pN: address/phase of outstanding reads, qualified by cmp_vld_p.
  always_ff @(posedge bist_clk) begin
    cmp_addr_p[0]  <= bist_addr[ADDR_W-1:0];
    cmp_phase_p[0] <= op_phase;
    for (int k = 1; k < RD_LAT; k++) begin
      cmp_addr_p[k]  <= cmp_addr_p[k-1];
      cmp_phase_p[k] <= cmp_phase_p[k-1];
    end
  end

endmodule

// File: tb/tb_mem_bist_march_ctrl.sv
module tb_mem_bist_march_ctrl;

  localparam int NM  = 3, AW  = 4, DP  = 16, DW  = 73, RL  = 1;
  localparam int NM2 = 2, AW2 = 5, DP2 = 20, DW2 = 8,  RL2 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, on, on2;

  logic [NM-1:0]    en;
  logic             we;
  logic [NM*AW-1:0] addr;
  logic [NM*DW-1:0] wdata, rdata;
  logic             busy, done;
  logic [NM-1:0]    fail;
  logic [AW-1:0]    faddr;
  logic [1:0]       fphase;

  logic [NM2-1:0]     en2;
  logic               we2;
  logic [NM2*AW2-1:0] addr2;
  logic [NM2*DW2-1:0] wdata2, rdata2;
  logic               busy2, done2;
  logic [NM2-1:0]     fail2;
  logic [AW2-1:0]     faddr2;
  logic [1:0]         fphase2;

  mem_bist_march_ctrl #(.NUM_MEM(NM), .ADDR_W(AW), .DEPTH(DP), .DATA_W(DW), .RD_LAT(RL)) dut_a (
    .bist_clk(clk), .bist_reset(rst), .bist_on(on), .bist_en(en), .bist_we(we),
    .bist_addr(addr), .bist_wr_data(wdata), .bist_rd_data(rdata), .bist_busy(busy),
    .bist_done(done), .bist_fail(fail), .bist_fail_addr(faddr), .bist_fail_phase(fphase));

  mem_bist_march_ctrl #(.NUM_MEM(NM2), .ADDR_W(AW2), .DEPTH(DP2), .DATA_W(DW2), .RD_LAT(RL2)) dut_b (
    .bist_clk(clk), .bist_reset(rst), .bist_on(on2), .bist_en(en2), .bist_we(we2),
    .bist_addr(addr2), .bist_wr_data(wdata2), .bist_rd_data(rdata2), .bist_busy(busy2),
    .bist_done(done2), .bist_fail(fail2), .bist_fail_addr(faddr2), .bist_fail_phase(fphase2));

  // Stuck-at faults shared by both memory models (only one DUT runs at a time).
  typedef struct { int m; int a; int b; bit sv; } fault_t;
  fault_t faults[$];

  // ---------------- memory models ----------------
  logic [DW-1:0]     mem_a [NM][DP];
  logic [DW2-1:0]    mem_b [NM2][DP2];
  logic [NM*DW-1:0]  rp_a  [RL];
  logic [NM2*DW2-1:0] rp_b [RL2];

  function automatic logic [NM*DW-1:0] rd_bus_a();
    logic [NM*DW-1:0] r;
    r = '0;
    for (int m = 0; m < NM; m++) begin
      if (en[m] && !we) begin
        int a;
        logic [DW-1:0] v;
        a = int'(addr[m*AW +: AW]);
        v = (a < DP) ? mem_a[m][a] : '0;
        foreach (faults[i]) if (faults[i].m == m && faults[i].a == a && faults[i].b < DW) v[faults[i].b] = faults[i].sv;
        r[m*DW +: DW] = v;
      end
    end
    return r;
  endfunction

  function automatic logic [NM2*DW2-1:0] rd_bus_b();
    logic [NM2*DW2-1:0] r;
    r = '0;
    for (int m = 0; m < NM2; m++) begin
      if (en2[m] && !we2) begin
        int a;
        logic [DW2-1:0] v;
        a = int'(addr2[m*AW2 +: AW2]);
        v = (a < DP2) ? mem_b[m][a] : '0;
        foreach (faults[i]) if (faults[i].m == m && faults[i].a == a && faults[i].b < DW2) v[faults[i].b] = faults[i].sv;
        r[m*DW2 +: DW2] = v;
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin
    for (int m = 0; m < NM; m++)
      if (en[m] && we && int'(addr[m*AW +: AW]) < DP) mem_a[m][int'(addr[m*AW +: AW])] <= wdata[m*DW +: DW];
    for (int m = 0; m < NM2; m++)
      if (en2[m] && we2 && int'(addr2[m*AW2 +: AW2]) < DP2) mem_b[m][int'(addr2[m*AW2 +: AW2])] <= wdata2[m*DW2 +: DW2];
    rp_a[0] <= rd_bus_a();
    for (int k = 1; k < RL; k++) rp_a[k] <= rp_a[k-1];
    rp_b[0] <= rd_bus_b();
    for (int k = 1; k < RL2; k++) rp_b[k] <= rp_b[k-1];
  end
  assign rdata  = rp_a[RL-1];
  assign rdata2 = rp_b[RL2-1];

  // ---------------- normalised view of the selected DUT ----------------
  logic       sel;
  logic       s_en_all, s_en_any, s_we, s_busy, s_done, s_rep, s_wd0, s_wd1;
  int         s_addr, s_faddr, s_fphase;
  logic [2:0] s_fail;
  always_comb begin
    if (sel) begin
      s_en_all = &en2;  s_en_any = |en2;  s_we = we2;  s_busy = busy2;  s_done = done2;
      s_addr   = int'(addr2[AW2-1:0]);
      s_rep    = (addr2 == {NM2{addr2[AW2-1:0]}});
      s_wd0    = (wdata2 == '0);  s_wd1 = &wdata2;
      s_fail   = {1'b0, fail2};  s_faddr = int'(faddr2);  s_fphase = int'(fphase2);
    end else begin
      s_en_all = &en;  s_en_any = |en;  s_we = we;  s_busy = busy;  s_done = done;
      s_addr   = int'(addr[AW-1:0]);
      s_rep    = (addr == {NM{addr[AW-1:0]}});
      s_wd0    = (wdata == '0);  s_wd1 = &wdata;
      s_fail   = fail;  s_faddr = int'(faddr);  s_fphase = int'(fphase);
    end
  end

  // ---------------- reference model ----------------
  typedef struct { bit we; int a; bit d; int ph; } op_t;
  op_t ops[$];

  function automatic void build_ops(input int d);
    ops.delete();
    for (int a = 0; a < d; a++) ops.push_back('{1'b1, a, 1'b0, 0});
    for (int a = 0; a < d; a++) begin
      ops.push_back('{1'b0, a, 1'b0, 1});
      ops.push_back('{1'b1, a, 1'b1, 0});
    end
    for (int a = d - 1; a >= 0; a--) begin
      ops.push_back('{1'b0, a, 1'b1, 2});
      ops.push_back('{1'b1, a, 1'b0, 0});
    end
    for (int a = d - 1; a >= 0; a--) ops.push_back('{1'b0, a, 1'b0, 3});
  endfunction

  // A read of (m,a) expecting value d mismatches if any stuck bit there disagrees with d.
  function automatic void predict(input int nm, output logic [2:0] f, output int fa, output int fp);
    f = '0; fa = 0; fp = 0;
    foreach (ops[i]) begin
      if (!ops[i].we) begin
        for (int m = 0; m < nm; m++) begin
          bit bad;
          bad = 1'b0;
          foreach (faults[j]) if (faults[j].m == m && faults[j].a == ops[i].a && faults[j].sv != ops[i].d) bad = 1'b1;
          if (bad) begin
            if (f == '0) begin fa = ops[i].a; fp = ops[i].ph; end
            f[m] = 1'b1;
          end
        end
      end
    end
  endfunction

  // ---------------- checking ----------------
  int checks = 0, errors = 0;
  int ff[3];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_on(input logic v);
    if (sel) on2 = v; else on = v;
  endtask

  task automatic run_full(input string tag, input logic [2:0] ef, input int ea, input int ep);
    int d, rl, done_cyc, seq_bad, first_bad, maxa;
    d = sel ? DP2 : DP;  rl = sel ? RL2 : RL;
    build_ops(d);
    done_cyc = 0; seq_bad = 0; first_bad = 0; maxa = 0;
    for (int m = 0; m < 3; m++) ff[m] = 0;
    @(negedge clk); set_on(1'b1);
    for (int k = 1; k <= 6 * d + rl + 20; k++) begin
      @(negedge clk);
      if (k == 1) chk({tag, "_fail_clr"}, s_fail, 0);
      if (k <= 6 * d) begin
        op_t o;
        logic ok;
        o  = ops[k-1];
        ok = s_en_all && s_busy && !s_done && s_rep && (s_we == o.we) && (s_addr == o.a) &&
             (!o.we || (o.d ? s_wd1 : s_wd0));
        if (!ok) begin seq_bad++; if (first_bad == 0) first_bad = k; end
      end else if (!s_done) begin
        if (s_en_any || (s_busy != (k <= 6 * d + rl))) begin seq_bad++; if (first_bad == 0) first_bad = k; end
      end
      if (s_en_any && s_addr > maxa) maxa = s_addr;
      for (int m = 0; m < 3; m++) if (s_fail[m] && ff[m] == 0) ff[m] = k;
      if (s_done) begin done_cyc = k; break; end
    end
    chk({tag, "_done_cycle"}, done_cyc, 6 * d + rl + 1);
    chk({tag, "_seq_bad_cycles(first)"}, {seq_bad, first_bad}, 0);
    chk({tag, "_max_addr"}, maxa, d - 1);
    chk({tag, "_fail"}, s_fail, ef);
    if (ef != 0) begin
      chk({tag, "_fail_addr"}, s_faddr, ea);
      chk({tag, "_fail_phase"}, s_fphase, ep);
    end
    set_on(1'b0);
    @(negedge clk);
    chk({tag, "_done_clr"}, s_done, 0);
    chk({tag, "_fail_kept"}, s_fail, ef);
  endtask

  typedef struct {
    string      name;
    logic [2:0] mmask;
    int         a;
    int         b;
    bit         sv;
    bit         same;
    logic [2:0] ef;
    int         ea;
    int         ep;
  } vec_t;

  initial begin
    vec_t tbl[5];
    rst = 1'b1; on = 1'b0; on2 = 1'b0; sel = 1'b0;

    tbl[0] = '{"ideal",      3'b000, 0,  0,  1'b0, 1'b0, 3'b000, 0,  0};
    tbl[1] = '{"sa1_m1_a7",  3'b010, 7,  5,  1'b1, 1'b0, 3'b010, 7,  1};
    tbl[2] = '{"sa0_m02_a3", 3'b101, 3,  40, 1'b0, 1'b1, 3'b101, 3,  2};
    tbl[3] = '{"sa1_m2_a15", 3'b100, 15, 72, 1'b1, 1'b0, 3'b100, 15, 1};
    tbl[4] = '{"sa0_m0_a0",  3'b001, 0,  0,  1'b0, 1'b0, 3'b001, 0,  2};

    repeat (3) @(negedge clk);
    chk("rst_a_outs", {en, we, addr, wdata, busy, done, fail, faddr, fphase}, 0);
    chk("rst_b_outs", {en2, we2, addr2, wdata2, busy2, done2, fail2, faddr2, fphase2}, 0);
    rst = 1'b0;

    // Directed fault table on the default-parameter instance.
    for (int i = 0; i < 5; i++) begin
      faults.delete();
      for (int m = 0; m < NM; m++) if (tbl[i].mmask[m]) faults.push_back('{m, tbl[i].a, tbl[i].b, tbl[i].sv});
      run_full(tbl[i].name, tbl[i].ef, tbl[i].ea, tbl[i].ep);
      if (tbl[i].same) chk({tbl[i].name, "_same_cycle"}, ff[0] == ff[2] && ff[0] != 0, 1);
    end

    // Randomised fault sets against the reference model.
    for (int r = 0; r < 6; r++) begin
      logic [2:0] ef;
      int ea, ep, nf;
      faults.delete();
      nf = $urandom_range(1, 2);
      for (int j = 0; j < nf; j++) begin
        fault_t f;
        f.m = $urandom_range(0, NM - 1); f.a = $urandom_range(0, DP - 1);
        f.b = $urandom_range(0, DW - 1); f.sv = 1'($urandom_range(0, 1));
        foreach (faults[q]) if (faults[q].m == f.m && faults[q].a == f.a && faults[q].b == f.b) f.b = (f.b + 1) % DW;
        faults.push_back(f);
      end
      build_ops(DP);
      predict(NM, ef, ea, ep);
      run_full($sformatf("rand%0d", r), ef, ea, ep);
    end

    // Abort at op cycle 40 with a fault already flagged, then a clean rerun.
    faults.delete();
    faults.push_back('{1, 2, 3, 1'b1});
    @(negedge clk); on = 1'b1;
    for (int k = 1; k <= 40; k++) @(negedge clk);
    on = 1'b0;
    @(negedge clk);
    chk("abort_en", en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_fail_kept", fail, 3'b010);
    repeat (2) @(negedge clk);
    chk("abort_idle", {en, busy, done}, 0);
    faults.delete();
    run_full("rerun", 3'b000, 0, 0);

    // Reset at op cycle 50 while the M2 read of addr 15 is still being compared.
    faults.delete();
    faults.push_back('{0, 15, 10, 1'b0});
    @(negedge clk); on = 1'b1;
    for (int k = 1; k <= 50; k++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_outs", {en, we, addr, wdata, busy, done, fail, faddr, fphase}, 0);
    @(negedge clk);
    chk("rst_mid_no_compare", fail, 0);
    on = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    faults.delete();

    // Alternate parameter set: deeper memory, 3-cycle read latency.
    sel = 1'b1;
    run_full("p2_ideal", 3'b000, 0, 0);
    faults.push_back('{1, 19, 0, 1'b1});
    run_full("p2_a19", 3'b010, 19, 1);
    faults.delete();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
